// File: rtl/dmux4_reg_if.sv
// Producer/consumer bundle for dmux4_reg: one valid/ready input stream and
// four valid/ready output channels packed side by side.
interface dmux4_reg_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;

  // Drives the producer inputs and the consumer readies.
  modport master (
    output in_data, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // The demultiplexer itself.
  modport slave (
    input  in_data, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/dmux4_reg.sv
// Registered 1-to-4 demultiplexer with one holding register per channel.
// Define DMUX4_ROUND_ROBIN_EN to ignore sel and rotate the target on every accept.
module dmux4_reg #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  dmux4_reg_if.slave bus
);

  logic [WIDTH-1:0]   data_q [4];
  logic [WIDTH-1:0]   data_d [4];
  logic [3:0]         valid_q;
  logic [3:0]         valid_d;
  logic [1:0]         tgt;
  logic               in_ready_w;
  logic               accept;
  logic [4*WIDTH-1:0] out_data_w;

`ifdef DMUX4_ROUND_ROBIN_EN
  logic [1:0] rr_q;
  logic [1:0] rr_d;

  assign tgt  = rr_q;
  // A stalled word leaves the pointer where it is; wrap 3 -> 0 is natural.
  assign rr_d = accept ? rr_q + 2'd1 : rr_q;

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 2'd0;
    else       rr_q <= rr_d;
  end
`else
  assign tgt = bus.sel;
`endif

  // Backpressure depends only on the addressed channel.
  assign in_ready_w = !reset && (!valid_q[tgt] || bus.out_ready[tgt]);
  assign accept     = bus.in_valid && in_ready_w;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    valid_d = valid_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      if (valid_q[i] && bus.out_ready[i]) valid_d[i] = 1'b0;
      if (accept && tgt == 2'(i)) begin
        data_d[i]  = bus.in_data;
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      // NOTE: the data registers are reset too, because out_data must read zero after reset.
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) data_q[i] <= data_d[i];
    end
  end

  always_comb begin
    out_data_w = '0;
    for (int i = 0; i < 4; i++) out_data_w[i*WIDTH +: WIDTH] = data_q[i];
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = valid_q & {4{!reset}};
  assign bus.out_data  = out_data_w;

endmodule
